flag_condition_unit: RTL and testbench
======================================

# flag_condition_unit

Consumer side of the ALU flag path in the microcontroller datapath. Latches the two-bit ZV flag vector produced beside the ALU into a flag register, evaluates 3-bit branch/conditional-execute condition codes against it through a valid/ready handshake with a registered result, and optionally saves/restores flags on a small LIFO for interrupt entry/return. Sits between the ALU flag output and the control unit's branch/predication logic.

## Interface
- STACK_DEPTH, 4, flag save-stack entries (≥2, power of two); unused when FLAG_STACK_EN undefined
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flags_we  in  1  load alu_flags into flag register this cycle
- alu_flags  in  2  {V, Z} from ALU (bit1 = V overflow, bit0 = Z zero)
- cond_valid  in  1  condition request valid
- cond  in  3  condition code
- cond_ready  out  1  unit can accept a request
- res_valid  out  1  result valid
- res_true  out  1  condition evaluated true
- res_ready  in  1  consumer accepts result
- push  in  1  save flags to stack (interrupt entry)
- pop  in  1  restore flags from stack (interrupt return)
- flags_q  out  2  current flag register {V, Z}
- stack_full  out  1  stack holds STACK_DEPTH entries
- stack_empty  out  1  stack holds zero entries
- stack_err  out  1  sticky overflow/underflow/conflict error

## Operation
- Condition codes: 000 AL true; 001 EQ Z; 010 NE ~Z; 011 VS V; 100 VC ~V; 101 EQV Z|V; 110 NV false; 111 reserved, evaluates false.
- Effective flags for evaluation: if flags_we asserted in the accepting cycle, alu_flags (bypass); else flags_q. Pop in same cycle: popped value takes precedence over both.
- Request accepted when cond_valid & cond_ready. cond_ready = ~res_valid | res_ready (single-entry output register, no bubble on back-to-back).
- Output register: on accept, res_valid←1, res_true←eval; on res_ready without new accept, res_valid←0; res_true holds until next accept.
- Flag register priority per edge: pop (valid) > flags_we > hold.
- Push: writes flags_q (pre-update value of that cycle) to stack top, pointer +1. Concurrent flags_we still updates flags_q.
- Pop: loads top entry into flags_q, pointer −1.
- Push when full or pop when empty: ignored, stack_err←1. Push and pop same cycle: both ignored, stack_err←1. stack_err cleared only by reset.
- Stack pointer width clog2(STACK_DEPTH)+1; full = pointer==STACK_DEPTH, empty = pointer==0.

## Timing
- Reset values: flags_q=00, res_valid=0, res_true=0, stack pointer=0, stack_full=0, stack_empty=1, stack_err=0, cond_ready=1.
- Evaluation latency: 1 cycle (accept at edge k, res_valid high after edge k).
- Flag update visible on flags_q one cycle after flags_we; visible to evaluation in the same cycle via bypass.
- Push/pop effect visible on flags_q, stack_full/empty after the edge.
- cond_ready, stack_full, stack_empty combinational from registered state and res_ready only.
- Reset mid-handshake: pending result dropped, stack contents discarded (entries need not be cleared, pointer is).

## Configuration
- FLAG_STACK_EN defined: save/restore stack present as above.
- Undefined: no stack storage; push/pop ignored; stack_full=0, stack_empty=1, stack_err=0 constant; flag register priority reduces to flags_we > hold.

## Test plan
- Reset, then cond=000 valid, res_ready=1 -> res_valid=1, res_true=1 next cycle; flags_q=00.
- flags_we=1, alu_flags=01 with cond=001 same cycle -> res_true=1 (bypass); next request cond=010 -> res_true=0; flags_q=01.
- res_ready=0 with result pending, cond_valid=1 -> cond_ready=0, res_true holds; raise res_ready -> new request accepted same cycle, result next cycle.
- Load flags 10, push, load 01, pop -> flags_q=10, stack_empty=1; cond=011 -> res_true=1.
- STACK_DEPTH=4: 4 pushes -> stack_full=1; 5th push -> pointer unchanged, stack_err=1; pop on empty after draining -> stack_err stays 1, flags_q unchanged.
- Build without FLAG_STACK_EN: push/pop pulses -> flags_q unchanged, stack_empty=1, stack_err=0; cond=111 -> res_true=0.

Source files
------------

// File: rtl/flag_condition_if.sv
// flag_condition_if: ALU flag input, condition request/result handshake and flag stack control/status.
interface flag_condition_if;
  logic flags_we;
  logic [1:0] alu_flags;
  logic cond_valid;
  logic [2:0] cond;
  logic cond_ready;
  logic res_valid;
  logic res_true;
  logic res_ready;
  logic push;
  logic pop;
  logic [1:0] flags_q;
  logic stack_full;
  logic stack_empty;
  logic stack_err;
  modport master (
    output flags_we, alu_flags, cond_valid, cond, res_ready, push, pop,
    input cond_ready, res_valid, res_true, flags_q, stack_full, stack_empty, stack_err
  );
  modport slave (
    input flags_we, alu_flags, cond_valid, cond, res_ready, push, pop,
    output cond_ready, res_valid, res_true, flags_q, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/flag_condition_unit.sv
// flag_condition_unit: {V,Z} flag register, registered condition evaluator, and
// optional interrupt flag save/restore LIFO enabled by FLAG_STACK_EN.
module flag_condition_unit #(
  parameter int STACK_DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  flag_condition_if.slave bus
);
  logic [1:0] flags;
  logic [1:0] eff;
  logic [1:0] pop_val;
  logic res_valid;
  logic res_true;
  logic accept;
  logic pop_ok;
  logic eval;
  assign bus.cond_ready = ~res_valid | bus.res_ready;
  assign accept = bus.cond_valid & bus.cond_ready;
  assign bus.res_valid = res_valid;
  assign bus.res_true = res_true;
  assign bus.flags_q = flags;
`ifdef FLAG_STACK_EN
  localparam int PW = $clog2(STACK_DEPTH) + 1;
  localparam logic [PW-1:0] FULL = PW'(STACK_DEPTH);
  logic [1:0] stack [STACK_DEPTH];
  logic [PW-1:0] ptr;
  logic [PW-2:0] top;
  logic push_ok;
  logic bad;
  logic err;
  // ptr==STACK_DEPTH wraps the low bits to 0, so top still lands on the last slot
  assign top = ptr[PW-2:0] - (PW-1)'(1);
  assign push_ok = bus.push & ~bus.pop & (ptr != FULL);
  assign pop_ok = bus.pop & ~bus.push & (ptr != '0);
  assign bad = (bus.push & bus.pop) | (bus.push & ptr == FULL) | (bus.pop & ptr == '0);
  assign pop_val = stack[top];
  assign bus.stack_full = ptr == FULL;
  assign bus.stack_empty = ptr == '0;
  assign bus.stack_err = err;
  always_ff @(posedge clk)
    if (push_ok) stack[ptr[PW-2:0]] <= flags;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      err <= 1'b0;
    end else begin
      ptr <= push_ok ? ptr + 1'b1 : pop_ok ? ptr - 1'b1 : ptr;
      err <= err | bad;
    end
`else
  logic unused_stack;
  assign unused_stack = bus.push ^ bus.pop;
  assign pop_ok = 1'b0;
  assign pop_val = 2'b00;
  assign bus.stack_full = 1'b0;
  assign bus.stack_empty = 1'b1;
  assign bus.stack_err = 1'b0;
`endif
  assign eff = pop_ok ? pop_val : bus.flags_we ? bus.alu_flags : flags;
  always_comb begin
    eval = 1'b0;
    eval = bus.cond == 3'd0 ? 1'b1 :
           bus.cond == 3'd1 ? eff[0] :
           bus.cond == 3'd2 ? ~eff[0] :
           bus.cond == 3'd3 ? eff[1] :
           bus.cond == 3'd4 ? ~eff[1] :
           bus.cond == 3'd5 ? eff[0] | eff[1] : 1'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      flags <= 2'b00;
      res_valid <= 1'b0;
      res_true <= 1'b0;
    end else begin
      flags <= pop_ok ? pop_val : bus.flags_we ? bus.alu_flags : flags;
      if (accept) begin
        res_valid <= 1'b1;
        res_true <= eval;
      end else if (bus.res_ready) res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_flag_condition_unit.sv
// tb_flag_condition_unit: directed test-plan sequences plus random traffic against a queue-based model.
module tb_flag_condition_unit;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [1:0] m_flags = 2'b00;
  logic m_rv = 1'b0;
  logic m_rt = 1'b0;
  logic m_err = 1'b0;
  logic [1:0] stk[$];
  flag_condition_if bus ();
  flag_condition_unit #(.STACK_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  function automatic logic ref_eval(input logic [2:0] c, input logic [1:0] f);
    logic v = f[1];
    logic z = f[0];
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return v;
      3'd4: return !v;
      3'd5: return z || v;
      default: return 1'b0;
    endcase
  endfunction
  task automatic check_state(input string tag);
    chk({tag, ".res_valid"}, 4'(bus.res_valid), 4'(m_rv));
    chk({tag, ".res_true"}, 4'(bus.res_true), 4'(m_rt));
    chk({tag, ".flags_q"}, 4'(bus.flags_q), 4'(m_flags));
`ifdef FLAG_STACK_EN
    chk({tag, ".full"}, 4'(bus.stack_full), 4'(stk.size() == DEPTH));
    chk({tag, ".empty"}, 4'(bus.stack_empty), 4'(stk.size() == 0));
`else
    chk({tag, ".full"}, 4'(bus.stack_full), 4'd0);
    chk({tag, ".empty"}, 4'(bus.stack_empty), 4'd1);
`endif
    chk({tag, ".err"}, 4'(bus.stack_err), 4'(m_err));
  endtask
  task automatic model_reset();
    m_flags = 2'b00;
    m_rv = 1'b0;
    m_rt = 1'b0;
    m_err = 1'b0;
    stk.delete();
  endtask
  task automatic step(input string tag, input logic fwe, input logic [1:0] af, input logic cv,
                      input logic [2:0] c, input logic rr, input logic ps, input logic pp);
    logic acc;
    logic popped;
    logic [1:0] pv;
    logic [1:0] eff;
    bus.flags_we = fwe;
    bus.alu_flags = af;
    bus.cond_valid = cv;
    bus.cond = c;
    bus.res_ready = rr;
    bus.push = ps;
    bus.pop = pp;
    #1;
    chk({tag, ".cond_ready"}, 4'(bus.cond_ready), 4'(!m_rv || rr));
    acc = cv && (!m_rv || rr);
    popped = 1'b0;
    pv = 2'b00;
`ifdef FLAG_STACK_EN
    if (ps && pp) m_err = 1'b1;
    else if (ps) begin
      if (stk.size() == DEPTH) m_err = 1'b1;
      else stk.push_back(m_flags);
    end else if (pp) begin
      if (stk.size() == 0) m_err = 1'b1;
      else begin
        pv = stk.pop_back();
        popped = 1'b1;
      end
    end
`endif
    eff = popped ? pv : fwe ? af : m_flags;
    if (acc) begin
      m_rv = 1'b1;
      m_rt = ref_eval(c, eff);
    end else if (rr) m_rv = 1'b0;
    m_flags = eff;
    @(posedge clk);
    #1;
    check_state(tag);
  endtask
  initial begin
    step("init", 0, 0, 0, 0, 1, 0, 0);
    chk("reset.cond_ready", 4'(bus.cond_ready), 4'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_state("reset");
    step("al", 0, 0, 1, 3'd0, 1, 0, 0);
    step("bypass_eq", 1, 2'b01, 1, 3'd1, 1, 0, 0);
    step("ne", 0, 0, 1, 3'd2, 1, 0, 0);
    step("hold_a", 0, 0, 1, 3'd0, 0, 0, 0);
    step("hold_b", 0, 0, 1, 3'd2, 0, 0, 0);
    step("hold_c", 0, 0, 1, 3'd2, 1, 0, 0);
    step("drain", 0, 0, 0, 0, 1, 0, 0);
    step("ld10", 1, 2'b10, 0, 0, 1, 0, 0);
    step("push", 0, 0, 0, 0, 1, 1, 0);
    step("ld01", 1, 2'b01, 0, 0, 1, 0, 0);
    step("pop", 0, 0, 0, 0, 1, 0, 1);
    step("vs", 0, 0, 1, 3'd3, 1, 0, 0);
    step("rsvd", 0, 0, 1, 3'd7, 1, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step("fill", 1, 2'(i), 0, 0, 1, 1, 0);
    for (int i = 0; i < DEPTH + 1; i++) step("drain_stk", 0, 0, 1, 3'd5, 1, 0, 1);
    step("pushpop", 0, 0, 0, 0, 1, 1, 1);
    step("pend", 1, 2'b11, 1, 3'd5, 0, 1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 600; i++)
      step("rand", 1'($urandom_range(0, 2) == 0), 2'($urandom), 1'($urandom_range(0, 2) != 0),
           3'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 6) == 0),
           1'($urandom_range(0, 6) == 0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
